// File: rtl/stepper_move_ctrl_if.sv
// Command/status bundle between a move command source and stepper_move_ctrl.
// master: drives start/dir_in/count_in/period_in/abort, reads status and step/dir.
// slave: the move controller, the other way round.
interface stepper_move_ctrl_if #(
  parameter int CNT_W = 16,
  parameter int PER_W = 16
);
  logic             start;
  logic             dir_in;
  logic [CNT_W-1:0] count_in;
  logic [PER_W-1:0] period_in;
  logic             abort;
  logic             step;
  logic             dir;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [CNT_W-1:0] remaining;

  modport master (
    output start, dir_in, count_in, period_in, abort,
    input  step, dir, busy, done, aborted, remaining
  );

  modport slave (
    input  start, dir_in, count_in, period_in, abort,
    output step, dir, busy, done, aborted, remaining
  );
endinterface

// File: rtl/stepper_move_ctrl.sv
// Move sequencer: emits count_in one-cycle step pulses, period_in cycles apart.
// Ports: clock, reset (async, active-high), bus (stepper_move_ctrl_if.slave).
module stepper_move_ctrl #(
  parameter int CNT_W = 16,
  parameter int PER_W = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  stepper_move_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [PER_W-1:0] timer;
  logic [PER_W-1:0] period;
  logic [CNT_W-1:0] rem_q;
  logic             step_q;
  logic             dir_q;
  logic             aborted_q;
  logic [PER_W-1:0] per_eff;

  // A zero period would never time out; run it as one step per clock.
  assign per_eff = (bus.period_in == '0) ? PER_W'(1) : bus.period_in;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      timer     <= '0;
      period    <= '0;
      rem_q     <= '0;
      step_q    <= 1'b0;
      dir_q     <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          step_q <= 1'b0;
          if (bus.start) begin
            dir_q     <= bus.dir_in;
            rem_q     <= bus.count_in;
            period    <= per_eff;
            timer     <= per_eff;
            aborted_q <= 1'b0;
            state     <= (bus.count_in != '0) ? RUN : DONE;
          end
        end
        RUN: begin
          if (bus.abort) begin
            step_q    <= 1'b0;
            aborted_q <= 1'b1;
            state     <= DONE;
          end else if (timer == PER_W'(1)) begin
            step_q <= 1'b1;
            timer  <= period;
            if (rem_q != '0)
              rem_q <= rem_q - CNT_W'(1);
            // Last pulse lands in the DONE cycle.
            if (rem_q == CNT_W'(1))
              state <= DONE;
          end else begin
            step_q <= 1'b0;
            timer  <= timer - PER_W'(1);
          end
        end
        DONE: begin
          step_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          step_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.step      = step_q;
  assign bus.dir       = dir_q;
  assign bus.remaining = rem_q;
  assign bus.aborted   = aborted_q;
  assign bus.busy      = (state == RUN) || (state == DONE);
  assign bus.done      = (state == DONE);

endmodule
